fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the core.
- Generalises the single-cycle PC register and halt logic into a decoupled unit with these elements:
  - a 1-cycle-latency synchronous imem request/response port;
  - a DEPTH-entry prefetch FIFO;
  - a valid/ready handshake to decode;
  - branch redirect with flush;
  - sticky halt and a bench freeze (test_halt).
- Sits between imem and control/decode; decode returns redirect and halt requests.

Parameters:
- ADDR_W, 64, PC/address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- INIT_PC, 0, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- test_halt  in  1  bench freeze: issue no requests and present no output while high.
- halt_req  in  1  decode requests a permanent halt.
- redirect_valid  in  1  branch taken; flush and refetch.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  fetch address; equals pc whenever imem_req_valid is high.
- imem_rdata  in  INSTR_W  instruction for the request issued in the previous cycle.
- out_valid  out  1  instruction available to decode.
- out_instr  out  INSTR_W  head-of-FIFO instruction.
- out_pc  out  ADDR_W  address of out_instr.
- out_ready  in  1  decode accepts; a pop occurs when out_valid && out_ready.
- pc  out  ADDR_W  next address to fetch.
- halted  out  1  sticky halt status.

Behaviour:
- Reset values: pc=INIT_PC, halted=0, imem_req_valid=0, out_valid=0, FIFO empty, in-flight flag=0. The first request is issued in the first cycle with reset low.
- imem contract:
  - imem always accepts a request.
  - imem_rdata is valid exactly 1 cycle after imem_req_valid.
  - The unit registers the in-flight flag and the request address; the response is pushed into the FIFO as {pc, instr}.
- Issue rule: imem_req_valid = !halted && !test_halt && !redirect_valid && !halt_req && (fifo_count + inflight < DEPTH). On issue, pc <= pc + 4, wrapping modulo 2^ADDR_W.
- Credit rule: the credit check guarantees the FIFO never overflows. Push and pop in the same cycle are legal at any occupancy, including full and empty.
- Output:
  - out_valid = FIFO non-empty && !test_halt && !halted.
  - out_instr and out_pc are stable while out_valid && !out_ready.
- Redirect (redirect_valid=1, not halting):
  - FIFO cleared the same cycle.
  - A response arriving next cycle for a pre-redirect request is discarded.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No issue in the redirect cycle; the first issue is at the target in the following cycle.
  - A pop presented in the redirect cycle still counts as consumed.
- Halt (halt_req=1):
  - halted <= 1 and pc holds.
  - FIFO flushed; any in-flight response discarded.
  - All further issue stops.
  - Sticky until reset.
  - halt_req wins over a simultaneous redirect_valid; in that case pc is not redirected.
- test_halt:
  - No new issue, no pop, pc holds.
  - An already in-flight response is still captured.
  - Resumes seamlessly when test_halt drops.
  - redirect_valid and halt_req are still honoured during test_halt.
- Priority: reset > halted > halt_req > redirect_valid > test_halt > normal.
- Reset mid-operation: all state returns to reset values; in-flight data is dropped.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds 32-bit outputs perf_fetched (pops accepted by decode) and perf_flushed (FIFO entries plus in-flight responses discarded by a redirect or halt).
  - Both counters are cleared by reset and saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; all other behaviour is identical.

Test Plan:
- Straight-line fetch: release reset with out_ready=1 and imem returning mem[addr>>2] -> out_pc sequence 0x0,0x4,0x8,... with the matching instructions; first out_valid 2 cycles after reset drops; sustained 1 instr/cycle.
- Backpressure: out_ready=0 for 10 cycles -> FIFO fills to DEPTH=4; at most 4 entries plus 0 in flight; pc stops at 0x10 plus issued count; no entry lost or duplicated after out_ready=1.
- Redirect: redirect_valid=1 with redirect_pc=0x103 while 3 entries are buffered and 1 is in flight -> all discarded; next out_pc=0x100, then 0x104.
- Halt vs redirect: halt_req=1 and redirect_valid=1 in the same cycle -> halted=1, pc unchanged, out_valid=0 forever, imem_req_valid=0; reset restores pc=INIT_PC.
- test_halt: assert for 5 cycles mid-stream -> out_valid=0, pc frozen, in-flight instruction retained; after release, the sequence continues without gaps.
- Wrap and perf: redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> next fetch at 0x0. With FETCH_PERF_EN, perf_fetched and perf_flushed match the bench-counted pops and discards.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction-fetch front end.
//
// Issues one fetch per cycle to a 1-cycle-latency synchronous imem, buffers the
// responses as {pc, instr} in a DEPTH-entry prefetch FIFO and hands them to decode
// over a valid/ready handshake. Decode can redirect the fetch stream (flush and
// refetch at a new target) or request a sticky halt. test_halt freezes the unit
// for the bench without losing an in-flight response.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   test_halt          freeze: no issue, no output, pc holds
//   halt_req           permanent halt request from decode (wins over redirect)
//   redirect_valid/pc  taken branch; target bits [1:0] forced to zero
//   imem_req_valid     fetch request this cycle, address on imem_addr (== pc)
//   imem_rdata         instruction for the request issued in the previous cycle
//   out_valid/instr/pc head of the prefetch FIFO towards decode
//   out_ready          decode accepts the head entry
//   pc                 next address to fetch
//   halted             sticky halt status
//   perf_fetched/flushed (only with FETCH_PERF_EN) saturating 32-bit counters of
//                      accepted pops and of entries/responses discarded by a flush
//
// Optional feature macro: FETCH_PERF_EN.
module fetch_unit #(
  parameter int unsigned      ADDR_W  = 64,
  parameter int unsigned      INSTR_W = 32,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [ADDR_W-1:0] INIT_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               test_halt,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               halted_q, halted_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_addr_q, inflight_addr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]  fifo_pc_q    [DEPTH];
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];

  logic [CntW:0] occupancy;
  logic          credit_ok;
  logic          issue;
  logic          flush;
  logic          pop;
  logic          push;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Entries buffered plus the one response still owed by imem must fit.
  assign occupancy = (CntW+1)'(count_q) + (CntW+1)'(inflight_q);
  assign credit_ok = occupancy < (CntW+1)'(DEPTH);

  assign issue = !reset && !halted_q && !test_halt && !redirect_valid && !halt_req && credit_ok;
  assign flush = !halted_q && (halt_req || redirect_valid);

  assign out_valid = !reset && (count_q != '0) && !test_halt && !halted_q;
  assign pop       = out_valid && out_ready;
  // A response landing in a flush cycle belongs to the old stream and is dropped.
  assign push      = inflight_q && !halted_q && !flush;

  assign imem_req_valid = issue;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign out_instr      = fifo_instr_q[rd_ptr_q];
  assign out_pc         = fifo_pc_q[rd_ptr_q];

  always_comb begin
    pc_d            = pc_q;
    halted_d        = halted_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;

    if (issue) begin
      pc_d            = pc_q + ADDR_W'(4);
      inflight_addr_d = pc_q;
    end

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      if (halt_req) begin
        halted_d = 1'b1;
      end else begin
        pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= INIT_PC;
      halted_q        <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      pc_q            <= pc_d;
      halted_q        <= halted_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_pc_q[wr_ptr_q]    <= inflight_addr_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [CntW:0] discard_cnt;
  logic [32:0]   flushed_sum;

  // A pop in the flush cycle is consumed by decode, not discarded.
  assign discard_cnt = flush ? ((CntW+1)'(count_q) - (CntW+1)'(pop) + (CntW+1)'(inflight_q))
                             : '0;
  assign flushed_sum = {1'b0, perf_flushed_q} + 33'(discard_cnt);

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
